// File: rtl/stepper_dispense_if.sv
// Recipe-controller / coil-driver handshake bundle for stepper_dispense_seq.
// master = controller side, slave = sequencer side.
interface stepper_dispense_if #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 10
);
    localparam int CH_W = $clog2(N_CH);

    // start is a one-cycle request honoured only while busy is low; dose_cnt and
    // half_step are captured on that same edge and ignored for the rest of the run.
    logic                    start;
    logic [N_CH*CNT_W-1:0]   dose_cnt;
    logic                    half_step;
    logic                    busy;
    logic                    done;
    logic [CH_W-1:0]         active_ch;
    logic [N_CH*4-1:0]       coil;
    logic [2:0]              dbg_state;

    modport master (
        output start, dose_cnt, half_step,
        input  busy, done, active_ch, coil, dbg_state
    );

    modport slave (
        input  start, dose_cnt, half_step,
        output busy, done, active_ch, coil, dbg_state
    );
endinterface

// File: rtl/stepper_dispense_seq.sv
// Multi-channel stepper dispensing sequencer: per channel, dose strokes of a forward
// run and a mirrored reverse run, full- or half-step, with idle moves between channels.
module stepper_dispense_seq #(
    parameter int N_CH             = 3,
    parameter int CNT_W            = 10,
    parameter int STEP_DIV         = 524288,
    parameter int STEPS_PER_STROKE = 64,
    parameter int MOVE_TICKS       = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    stepper_dispense_if.slave bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int SPS_W = (STEPS_PER_STROKE > 1) ? $clog2(STEPS_PER_STROKE) : 1;
    localparam int MV_W  = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_FWD, S_REV, S_MOVE, S_DONE
    } state_t;

    state_t                state, state_nx;
    logic [DIV_W-1:0]      div_cnt;
    logic                  tick;
    logic                  accept;
    logic [CH_W-1:0]       ch, ch_nx;
    logic [N_CH*CNT_W-1:0] dose_q;
    logic                  hs_q;
    logic [CNT_W-1:0]      dose_arr [N_CH];
    logic [CNT_W-1:0]      dose_cur;
    logic [2:0]            p, p_nx;
    logic [2:0]            step_sz;
    logic [SPS_W-1:0]      step_cnt, step_cnt_nx;
    logic [CNT_W-1:0]      dose_done, dose_done_nx;
    logic [MV_W-1:0]       move_cnt, move_cnt_nx;
    logic                  rest_q, rest_nx;
    logic [N_CH*4-1:0]     coil_q, coil_nx;

    function automatic logic [3:0] phase(input logic [2:0] idx);
        case (idx)
            3'd0:    phase = 4'b0001;
            3'd1:    phase = 4'b0011;
            3'd2:    phase = 4'b0010;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0100;
            3'd5:    phase = 4'b1100;
            3'd6:    phase = 4'b1000;
            default: phase = 4'b1001;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) dose_arr[i] = dose_q[i*CNT_W +: CNT_W];
    end

    assign dose_cur = dose_arr[ch];
    assign accept   = (state == S_IDLE) && bus.start;
    assign tick     = (div_cnt == DIV_W'(STEP_DIV - 1));
    assign step_sz  = hs_q ? 3'd1 : 3'd2;

    always_comb begin
        state_nx     = state;
        ch_nx        = ch;
        p_nx         = p;
        step_cnt_nx  = step_cnt;
        dose_done_nx = dose_done;
        move_cnt_nx  = move_cnt;
        rest_nx      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    ch_nx    = '0;
                    state_nx = S_SELECT;
                end
            end
            S_SELECT: begin
                dose_done_nx = '0;
                move_cnt_nx  = '0;
                if (dose_cur != '0) begin
                    p_nx        = '0;
                    step_cnt_nx = '0;
                    state_nx    = S_FWD;
                end else if (ch == CH_W'(N_CH - 1)) begin
                    state_nx = S_DONE;
                end else begin
                    ch_nx = ch + 1'b1;
                end
            end
            S_FWD: begin
                if (tick) begin
                    p_nx = p + step_sz;
                    if (step_cnt == SPS_W'(STEPS_PER_STROKE - 1)) begin
                        step_cnt_nx = '0;
                        state_nx    = S_REV;
                    end else begin
                        step_cnt_nx = step_cnt + 1'b1;
                    end
                end
            end
            S_REV: begin
                if (tick) begin
                    p_nx = p - step_sz;
                    if (step_cnt == SPS_W'(STEPS_PER_STROKE - 1)) begin
                        step_cnt_nx  = '0;
                        dose_done_nx = dose_done + 1'b1;
                        if (dose_done_nx != dose_cur) begin
                            state_nx = S_FWD;
                        end else begin
                            rest_nx  = 1'b1;
                            state_nx = (ch == CH_W'(N_CH - 1)) ? S_DONE : S_MOVE;
                        end
                    end else begin
                        step_cnt_nx = step_cnt + 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (tick) begin
                    if (move_cnt == MV_W'(MOVE_TICKS - 1)) begin
                        move_cnt_nx = '0;
                        ch_nx       = ch + 1'b1;
                        state_nx    = S_SELECT;
                    end else begin
                        move_cnt_nx = move_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // coil is a registered image of p, so it trails each step by one cycle;
    // rest_q keeps the drive on for that trailing cycle so the 0001 rest phase shows.
    always_comb begin
        coil_nx = '0;
        if (state == S_FWD || state == S_REV || rest_q) begin
            for (int i = 0; i < N_CH; i++) begin
                if (CH_W'(i) == ch) coil_nx[i*4 +: 4] = phase(p);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            ch        <= '0;
            dose_q    <= '0;
            hs_q      <= 1'b0;
            p         <= '0;
            step_cnt  <= '0;
            dose_done <= '0;
            move_cnt  <= '0;
            rest_q    <= 1'b0;
            coil_q    <= '0;
        end else begin
            state     <= state_nx;
            ch        <= ch_nx;
            p         <= p_nx;
            step_cnt  <= step_cnt_nx;
            dose_done <= dose_done_nx;
            move_cnt  <= move_cnt_nx;
            rest_q    <= rest_nx;
            coil_q    <= coil_nx;
            if (accept) begin
                dose_q <= bus.dose_cnt;
                hs_q   <= bus.half_step;
            end
            // Tick phase restarts at accept and the counter parks at 0 whenever idle.
            if (accept || tick || state_nx == S_IDLE) div_cnt <= '0;
            else                                      div_cnt <= div_cnt + 1'b1;
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.active_ch = ch;
    assign bus.coil      = coil_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_stepper_dispense_seq.sv
// Bench for stepper_dispense_seq: two instances (stroke depth 4 and 8) checked
// against a stroke-level coil trace model and an arithmetic timing model.
module tb_stepper_dispense_seq;
    localparam int N_CH       = 3;
    localparam int CNT_W      = 4;
    localparam int STEP_DIV   = 4;
    localparam int MOVE_TICKS = 2;
    localparam int SPS_A      = 4;
    localparam int SPS_B      = 8;
    localparam int CH_W       = $clog2(N_CH);
    localparam int CW         = N_CH * 4;
    localparam int DW         = N_CH * CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stepper_dispense_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus_a ();
    stepper_dispense_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus_b ();

    stepper_dispense_seq #(.N_CH(N_CH), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV),
        .STEPS_PER_STROKE(SPS_A), .MOVE_TICKS(MOVE_TICKS)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));

    stepper_dispense_seq #(.N_CH(N_CH), .CNT_W(CNT_W), .STEP_DIV(STEP_DIV),
        .STEPS_PER_STROKE(SPS_B), .MOVE_TICKS(MOVE_TICKS)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit sel = 1'b0;
    bit mon_on = 1'b0;
    int done_cnt = 0;
    logic [CW-1:0] last_coil = '0;
    logic [CW-1:0] trace_q[$];
    logic [CW-1:0] exp_q[$];
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

    logic [CW-1:0]   coil_m;
    logic            busy_m, done_m;
    logic [CH_W-1:0] ch_m;

    always_comb begin
        if (sel) begin
            coil_m = bus_b.coil; busy_m = bus_b.busy; done_m = bus_b.done; ch_m = bus_b.active_ch;
        end else begin
            coil_m = bus_a.coil; busy_m = bus_a.busy; done_m = bus_a.done; ch_m = bus_a.active_ch;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Compressed coil trace: one entry per change of the whole coil bus.
    always @(negedge clk) begin
        if (mon_on) begin
            if (coil_m !== last_coil) begin
                trace_q.push_back(coil_m);
                last_coil = coil_m;
            end
            if (done_m === 1'b1) done_cnt++;
        end
    end

    // Expected trace: each stroke walks p forward then back from 0; zero between channels.
    function automatic void build_exp(input logic [DW-1:0] dv, input bit hs, input int sps);
        logic [CW-1:0] last, v;
        int p, st, d;
        exp_q.delete();
        last = '0;
        st = hs ? 1 : 2;
        for (int c = 0; c < N_CH; c++) begin
            d = int'(dv[c*CNT_W +: CNT_W]);
            for (int s = 0; s < d; s++) begin
                p = 0;
                for (int i = 0; i <= 2 * sps; i++) begin
                    if (i > 0) p = (i <= sps) ? (p + st) % 8 : (p + 8 - st) % 8;
                    v = CW'(tbl[p]) << (4 * c);
                    if (v !== last) begin exp_q.push_back(v); last = v; end
                end
            end
            if (d != 0) begin exp_q.push_back('0); last = '0; end
        end
    endfunction

    // Edge at which DONE is entered, given the accept edge k; ticks land on k + n*STEP_DIV.
    function automatic int exp_done_edge(input int k, input logic [DW-1:0] dv, input int sps);
        int t, first, e, d;
        t = k;
        for (int c = 0; c < N_CH; c++) begin
            d = int'(dv[c*CNT_W +: CNT_W]);
            if (d == 0) begin
                if (c == N_CH - 1) return t + 1;
                t++;
            end else begin
                first = k + STEP_DIV * ((t + 2 - k + STEP_DIV - 1) / STEP_DIV);
                e = first + STEP_DIV * (2 * sps * d - 1);
                if (c == N_CH - 1) return e;
                t = e + STEP_DIV * MOVE_TICKS;
            end
        end
        return -1;
    endfunction

    function automatic int trace_diff();
        if (trace_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (trace_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic start_seq(input bit s, input logic [DW-1:0] dv, input bit hs, output int k);
        @(posedge clk); #1;
        sel = s;
        trace_q.delete();
        last_coil = '0;
        done_cnt = 0;
        mon_on = 1'b1;
        if (s) begin bus_b.dose_cnt = dv; bus_b.half_step = hs; bus_b.start = 1'b1; end
        else   begin bus_a.dose_cnt = dv; bus_a.half_step = hs; bus_a.start = 1'b1; end
        k = cyc + 1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done(output int d, output bit ok);
        ok = 1'b0;
        d = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin ok = 1'b1; d = cyc; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus_a.busy); end
        if (bus_a.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", bus_a.done); end
        if (bus_a.active_ch !== '0) begin failures++; $display("FAIL rst_ch: got %0d expected 0", bus_a.active_ch); end
        if (bus_a.coil !== '0 || bus_b.coil !== '0) begin failures++; $display("FAIL rst_coil: got %h/%h expected 0", bus_a.coil, bus_b.coil); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks += 2;
        if ({bus_a.busy, bus_a.done, bus_b.busy, bus_b.done} !== 4'b0) begin
            failures++; $display("FAIL idle_flags: got %b expected 0000", {bus_a.busy, bus_a.done, bus_b.busy, bus_b.done});
        end
        if (bus_a.coil !== '0 || bus_a.active_ch !== '0) begin
            failures++; $display("FAIL idle_outputs: got coil %h ch %0d expected 0/0", bus_a.coil, bus_a.active_ch);
        end
    endtask

    task automatic test_full_step();
        logic [DW-1:0] dv;
        int k, d, df;
        bit ok;
        dv = {4'd2, 4'd0, 4'd1};
        build_exp(dv, 1'b0, SPS_A);
        start_seq(1'b0, dv, 1'b0, k);
        wait_done(d, ok);
        repeat (3) @(negedge clk);
        checks += 5;
        if (!ok) begin failures++; $display("FAIL full_timeout: no done within budget"); end
        if (d !== exp_done_edge(k, dv, SPS_A)) begin failures++; $display("FAIL full_done_time: got edge %0d expected %0d", d - k, exp_done_edge(k, dv, SPS_A) - k); end
        if (done_cnt !== 1) begin failures++; $display("FAIL full_done_pulse: got %0d cycles expected 1", done_cnt); end
        df = trace_diff();
        if (df != -1) begin failures++; $display("FAIL full_trace: diff at %0d, got %0d entries expected %0d", df, trace_q.size(), exp_q.size()); end
        if (ch_m !== CH_W'(N_CH - 1) || busy_m !== 1'b0) begin failures++; $display("FAIL full_end: got ch %0d busy %b expected %0d/0", ch_m, busy_m, N_CH - 1); end
    endtask

    task automatic test_half_step();
        logic [DW-1:0] dv;
        int k, d, df;
        bit ok;
        dv = {4'd0, 4'd0, 4'd1};
        build_exp(dv, 1'b1, SPS_B);
        start_seq(1'b1, dv, 1'b1, k);
        wait_done(d, ok);
        repeat (3) @(negedge clk);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL half_timeout: no done within budget"); end
        if (d !== exp_done_edge(k, dv, SPS_B)) begin failures++; $display("FAIL half_done_time: got edge %0d expected %0d", d - k, exp_done_edge(k, dv, SPS_B) - k); end
        if (done_cnt !== 1) begin failures++; $display("FAIL half_done_pulse: got %0d cycles expected 1", done_cnt); end
        df = trace_diff();
        if (df != -1) begin failures++; $display("FAIL half_trace: diff at %0d, got %0d entries expected %0d", df, trace_q.size(), exp_q.size()); end
    endtask

    task automatic test_zero_dose();
        int k;
        bit eb, ed;
        start_seq(1'b0, '0, 1'b0, k);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            eb = (j <= 3);
            ed = (j == 3);
            checks++;
            if (busy_m !== eb || done_m !== ed) begin
                failures++; $display("FAIL zero_timeline_%0d: got busy %b done %b expected %b %b", j, busy_m, done_m, eb, ed);
            end
        end
        checks++;
        if (trace_q.size() != 0) begin failures++; $display("FAIL zero_coil: got %0d coil changes expected 0", trace_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] dv1, dv2;
        int k, d, df;
        bit ok;
        dv1 = {4'd0, 4'd1, 4'd2};
        dv2 = {4'd1, 4'd0, 4'd1};
        build_exp(dv1, 1'b0, SPS_A);
        start_seq(1'b0, dv1, 1'b0, k);
        repeat (20) @(posedge clk);
        #1 bus_a.start = 1'b1; bus_a.dose_cnt = {4'd3, 4'd3, 4'd3}; bus_a.half_step = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        wait_done(d, ok);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL midrun_timeout: no done within budget"); end
        if (d !== exp_done_edge(k, dv1, SPS_A)) begin failures++; $display("FAIL midrun_done_time: got edge %0d expected %0d", d - k, exp_done_edge(k, dv1, SPS_A) - k); end
        df = trace_diff();
        if (df != -1) begin failures++; $display("FAIL midrun_trace: diff at %0d, got %0d entries expected %0d", df, trace_q.size(), exp_q.size()); end
        // Restart during the first IDLE cycle after done.
        build_exp(dv2, 1'b0, SPS_A);
        start_seq(1'b0, dv2, 1'b0, k);
        wait_done(d, ok);
        repeat (3) @(negedge clk);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL b2b_timeout: no done within budget"); end
        if (d !== exp_done_edge(k, dv2, SPS_A)) begin failures++; $display("FAIL b2b_done_time: got edge %0d expected %0d", d - k, exp_done_edge(k, dv2, SPS_A) - k); end
        df = trace_diff();
        if (df != -1) begin failures++; $display("FAIL b2b_trace: diff at %0d, got %0d entries expected %0d", df, trace_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid_run();
        logic [DW-1:0] dv;
        logic [3:0] sl, prev;
        int k, d, df, seen;
        bit ok;
        dv = {4'd2, 4'd0, 4'd1};
        start_seq(1'b0, dv, 1'b0, k);
        seen = 0; prev = '0; ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            sl = bus_a.coil[8 +: 4];
            if (sl == 4'b1000 && prev != 4'b1000) seen++;
            prev = sl;
            if (seen == 2) ok = 1'b1;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL midrev_timeout: ch2 reverse run not reached"); end
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (bus_a.coil !== '0 || bus_a.busy !== 1'b0) begin failures++; $display("FAIL async_rst: got coil %h busy %b expected 0/0", bus_a.coil, bus_a.busy); end
        if (bus_a.done !== 1'b0 || bus_a.active_ch !== '0) begin failures++; $display("FAIL async_rst_ch: got done %b ch %0d expected 0/0", bus_a.done, bus_a.active_ch); end
        @(posedge clk); #1 rst_n = 1'b1;
        dv = {4'd1, 4'd0, 4'd0};
        build_exp(dv, 1'b0, SPS_A);
        start_seq(1'b0, dv, 1'b0, k);
        wait_done(d, ok);
        repeat (3) @(negedge clk);
        checks += 3;
        if (!ok) begin failures++; $display("FAIL post_rst_timeout: no done within budget"); end
        if (d !== exp_done_edge(k, dv, SPS_A)) begin failures++; $display("FAIL post_rst_done_time: got edge %0d expected %0d", d - k, exp_done_edge(k, dv, SPS_A) - k); end
        df = trace_diff();
        if (df != -1) begin failures++; $display("FAIL post_rst_trace: diff at %0d, got %0d entries expected %0d", df, trace_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        logic [DW-1:0] dv;
        bit hs, ok;
        int k, d, df;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < N_CH; c++) dv[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
            hs = 1'($urandom_range(0, 1));
            build_exp(dv, hs, SPS_A);
            start_seq(1'b0, dv, hs, k);
            wait_done(d, ok);
            repeat (3) @(negedge clk);
            checks += 4;
            if (!ok) begin failures++; $display("FAIL rand%0d_timeout: no done within budget", r); end
            if (d !== exp_done_edge(k, dv, SPS_A)) begin failures++; $display("FAIL rand%0d_done_time: got edge %0d expected %0d (dose %h hs %b)", r, d - k, exp_done_edge(k, dv, SPS_A) - k, dv, hs); end
            if (done_cnt !== 1) begin failures++; $display("FAIL rand%0d_done_pulse: got %0d cycles expected 1", r, done_cnt); end
            df = trace_diff();
            if (df != -1) begin failures++; $display("FAIL rand%0d_trace: diff at %0d, got %0d entries expected %0d (dose %h hs %b)", r, df, trace_q.size(), exp_q.size(), dv, hs); end
        end
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.dose_cnt = '0; bus_a.half_step = 1'b0;
        bus_b.start = 1'b0; bus_b.dose_cnt = '0; bus_b.half_step = 1'b0;
        test_reset();
        test_full_step();
        test_half_step();
        test_zero_dose();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stepper_dispense_seq.md
# stepper_dispense_seq

Parametrised multi-channel stepper dispensing sequencer. Drives N_CH unipolar stepper channels one after another. Each channel performs a programmable number of dose strokes; one stroke is a forward run of STEPS_PER_STROKE steps followed by an equal reverse run. Full-step or half-step drive is selectable. The block sits between the colour/recipe controller, which supplies per-channel dose counts and a start pulse, and the motor coil drivers. It replaces the fixed three-channel, fixed-depth dispenser with one that has configurable channel count, dose counts, step rate, stroke depth and step mode, and a start/busy/done handshake.

## Interface
- N_CH, 3: number of motor channels (≥2).
- CNT_W, 10: dose count width per channel.
- STEP_DIV, 524288: clk cycles per step tick (≥2).
- STEPS_PER_STROKE, 64: steps per forward (and per reverse) half-stroke (≥1).
- MOVE_TICKS, 256: idle ticks between consecutive dosed channels (≥1).

Ports:
- clk  in  1  sole clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- dose_cnt  in  N_CH*CNT_W  channel i dose count at bits [i*CNT_W +: CNT_W]; latched on accept.
- half_step  in  1  1 = half-step, 0 = full-step; latched on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sequence completion.
- active_ch  out  $clog2(N_CH)  channel currently selected.
- coil  out  N_CH*4  channel i coils at bits [i*4 +: 4].

## Operation
- Phase table, index p = 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Step size: full-step = 2 (even p only), half-step = 1.
- Forward direction: p = p + step mod 8. Reverse direction: p = p − step mod 8.
- Tick generator: counter is cleared on start accept and counts 0..STEP_DIV−1 while busy. tick = 1 for one clk when the counter equals STEP_DIV−1. The counter is held at 0 in IDLE.
- States: IDLE, SELECT, FWD, REV, MOVE, DONE.
- IDLE + start: latch dose_cnt and half_step, set ch = 0, and go to SELECT. start in any other state is ignored.
- SELECT (one cycle):
  - dose[ch] ≠ 0: set p = 0 and step_cnt = 0, and go to FWD.
  - dose[ch] = 0 and ch < N_CH−1: increment ch and stay in SELECT. Skipped channels get no MOVE.
  - dose[ch] = 0 and ch = N_CH−1: go to DONE.
- FWD: on each tick, advance p forward and increment step_cnt. On the tick where step_cnt = STEPS_PER_STROKE−1, clear step_cnt and go to REV.
- REV: same as FWD but p steps in reverse. At the end of the reverse run, increment dose_done:
  - dose_done < dose[ch]: go to FWD.
  - dose_done = dose[ch] and ch < N_CH−1: go to MOVE.
  - dose_done = dose[ch] and ch = N_CH−1: go to DONE.
- dose_done is CNT_W wide, is cleared in SELECT, and is compared by equality. The maximum count is 2^CNT_W−1 strokes.
- MOVE: count MOVE_TICKS ticks, then increment ch and go to SELECT.
- DONE (one cycle): done = 1, then go to IDLE.
- coil is registered:
  - In FWD/REV, the slice for active_ch = table[p]; all other slices = 0000.
  - In IDLE, SELECT, MOVE and DONE, all coil bits are 0.
  - p returns to 0 after each complete stroke, so each stroke starts and ends on 0001.
- active_ch = ch. It is held after completion until the next accept.
- rst_n low (async, at any time, including mid-stroke): state = IDLE, and busy, done, active_ch, coil, all counters and p = 0. No partial state survives reset.

## Timing
- start sampled high at edge k (in IDLE): state = SELECT and busy = 1 from k+1.
- SELECT → FWD at the next edge. coil shows 0001 on the cycle after FWD is entered.
- First tick occurs STEP_DIV cycles after accept. coil updates the cycle after each tick.
- One stroke = 2*STEPS_PER_STROKE ticks. One MOVE = MOVE_TICKS ticks.
- DONE lasts 1 cycle, with done = 1 and busy = 1. IDLE follows with busy = 0.
- A new start is accepted no earlier than the first IDLE cycle.
- Changes to dose_cnt or half_step while busy have no effect.

## Test plan
Parameters for all scenarios unless stated: N_CH=3, STEP_DIV=4, STEPS_PER_STROKE=4, MOVE_TICKS=2, CNT_W=4.

- Reset: hold rst_n low → busy, done, active_ch and coil all 0. Release rst_n with no start → outputs stay 0.
- Full-step, dose {ch0=1, ch1=0, ch2=2}:
  - ch0 coil = 0001, 0010, 0100, 1000, 0001, then 1000, 0100, 0010, 0001.
  - MOVE of 2 ticks with coil = 0.
  - ch1 skipped with no MOVE.
  - ch2 repeats the stroke twice.
  - done pulses once, exactly one cycle.
- Half-step, dose {1,0,0}, STEPS_PER_STROKE=8:
  - ch0 forward: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001, 0001.
  - Reverse is the exact mirror.
  - Other coil slices stay 0 throughout.
- All doses 0, start at edge k: SELECT at k+1..k+3, done = 1 at k+4, busy = 0 at k+5, coil never nonzero.
- start re-pulsed, and dose_cnt changed, mid-run → no effect on sequence or timing. start in the first IDLE cycle after done → accepted.
- rst_n asserted mid-REV on ch2 → coil = 0 and busy = 0 asynchronously. After release, a new start with dose {0,0,1} runs ch2 only, with p starting at 0001.
